// File: rtl/wb_pkg.sv
// Shared Wishbone definitions: bus widths, responder FSM encoding and wait-counter width.
package wb_pkg;

  localparam int WB_DW     = 32;
  localparam int WB_SELW   = 4;
  localparam int WB_AW     = 32;
  localparam int WB_WCNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2
  } wb_state_t;

endpackage

// File: rtl/wb_ram_slave_if.sv
// Wishbone classic bus bundle between an initiator and the RAM responder.
// The err signal only exists when WB_SLV_ERR_EN is defined.
interface wb_ram_slave_if;
  import wb_pkg::*;

  logic               cyc;
  logic               stb;
  logic               we;
  logic [WB_SELW-1:0] sel;
  logic [WB_AW-1:0]   adr;
  logic [WB_DW-1:0]   dat_w;
  logic [WB_DW-1:0]   dat_r;
  logic               ack;
`ifdef WB_SLV_ERR_EN
  logic               err;
`endif

  modport master (
    output cyc, stb, we, sel, adr, dat_w,
`ifdef WB_SLV_ERR_EN
    input  err,
`endif
    input  dat_r, ack
  );

  modport slave (
    input  cyc, stb, we, sel, adr, dat_w,
`ifdef WB_SLV_ERR_EN
    output err,
`endif
    output dat_r, ack
  );

endinterface

// File: rtl/wb_ram_bytewe.sv
// Word-wide RAM with per-byte write enables and a registered read port that can be cleared.
module wb_ram_bytewe
  import wb_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic               clk,
  input  logic               arst_n,
  input  logic [WB_SELW-1:0] byte_we,
  input  logic [ADDR_W-1:0]  addr,
  input  logic [WB_DW-1:0]   wdata,
  input  logic               rd_en,
  input  logic               rd_clr,
  output logic [WB_DW-1:0]   rdata
);

  logic [WB_DW-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    for (int i = 0; i < WB_SELW; i++) begin
      if (byte_we[i]) begin
        mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  // Read data holds between reads so the bus sees the last completed read.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      rdata <= '0;
    end else if (rd_clr) begin
      rdata <= '0;
    end else if (rd_en) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/wb_ram_slave.sv
// Wishbone classic RAM responder with WAIT_STATES cycles between request and acknowledge.
// Define WB_SLV_ERR_EN to answer out-of-range addresses with err instead of aliasing.
module wb_ram_slave
  import wb_pkg::*;
#(
  parameter int ADDR_W      = 10,
  parameter int WAIT_STATES = 1
) (
  input logic           i_clk,
  input logic           i_arst_n,
  wb_ram_slave_if.slave wb
);

  localparam logic [WB_WCNT_W-1:0] WAIT_LOAD =
    (WAIT_STATES > 0) ? WB_WCNT_W'(WAIT_STATES - 1) : '0;

  wb_state_t            state, next_state;
  logic [WB_WCNT_W-1:0] cnt_q, cnt_d;
  logic                 lat_load;
  logic [WB_AW-1:0]     adr_q;
  logic                 we_q;
  logic [WB_SELW-1:0]   sel_q;
  logic [WB_DW-1:0]     dat_q;
  logic                 ack_q;
  logic                 err_q;

  logic                 req;
  logic [WB_AW-1:0]     cur_adr;
  logic                 cur_we;
  logic [WB_SELW-1:0]   cur_sel;
  logic [WB_DW-1:0]     cur_dat;
  logic                 addr_err;
  logic                 enter_ack;
  logic [WB_SELW-1:0]   byte_we;
  logic                 rd_en;
  logic                 rd_clr;
  logic [WB_DW-1:0]     ram_rdata;

  assign req = wb.cyc & wb.stb;

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      state <= ST_IDLE;
      cnt_q <= '0;
    end else begin
      state <= next_state;
      cnt_q <= cnt_d;
    end
  end

  // A request dropped while waiting aborts the transfer without any bus response.
  always_comb begin
    next_state = state;
    cnt_d      = cnt_q;
    lat_load   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (req) begin
          lat_load = 1'b1;
          if (WAIT_STATES > 0) begin
            next_state = ST_WAIT;
            cnt_d      = WAIT_LOAD;
          end else begin
            next_state = ST_ACK;
          end
        end
      end
      ST_WAIT: begin
        if (!req) begin
          next_state = ST_IDLE;
        end else if (cnt_q == '0) begin
          next_state = ST_ACK;
        end else begin
          cnt_d = cnt_q - WB_WCNT_W'(1);
        end
      end
      ST_ACK:  next_state = ST_IDLE;
      default: next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      adr_q <= '0;
      we_q  <= 1'b0;
      sel_q <= '0;
      dat_q <= '0;
    end else if (lat_load) begin
      adr_q <= wb.adr;
      we_q  <= wb.we;
      sel_q <= wb.sel;
      dat_q <= wb.dat_w;
    end
  end

  // With no wait states the access completes straight from IDLE, before the latch is loaded.
  assign cur_adr = (state == ST_IDLE) ? wb.adr   : adr_q;
  assign cur_we  = (state == ST_IDLE) ? wb.we    : we_q;
  assign cur_sel = (state == ST_IDLE) ? wb.sel   : sel_q;
  assign cur_dat = (state == ST_IDLE) ? wb.dat_w : dat_q;

`ifdef WB_SLV_ERR_EN
  assign addr_err = ((cur_adr >> ADDR_W) != '0);
`else
  logic unused_adr_hi;
  assign unused_adr_hi = ^(cur_adr >> ADDR_W);
  assign addr_err      = 1'b0;
`endif

  assign enter_ack = (next_state == ST_ACK) && i_arst_n;
  assign byte_we   = (enter_ack && cur_we && !addr_err) ? cur_sel : '0;
  assign rd_en     = enter_ack && !cur_we && !addr_err;
  assign rd_clr    = enter_ack && addr_err;

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      ack_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      ack_q <= enter_ack && !addr_err;
      err_q <= enter_ack && addr_err;
    end
  end

  wb_ram_bytewe #(
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk     (i_clk),
    .arst_n  (i_arst_n),
    .byte_we (byte_we),
    .addr    (cur_adr[ADDR_W-1:0]),
    .wdata   (cur_dat),
    .rd_en   (rd_en),
    .rd_clr  (rd_clr),
    .rdata   (ram_rdata)
  );

  assign wb.ack   = ack_q;
  assign wb.dat_r = ram_rdata;
`ifdef WB_SLV_ERR_EN
  assign wb.err   = err_q;
`else
  logic unused_err;
  assign unused_err = err_q;
`endif

endmodule

// File: tb/tb_wb_ram_slave.sv
// Directed bench for wb_ram_slave: three instances with 1, 3 and 0 wait states on one clock.
// Index 0 = WAIT_STATES 1, index 1 = WAIT_STATES 3, index 2 = WAIT_STATES 0.
module tb_wb_ram_slave;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        cyc_m [3];
  logic        stb_m [3];
  logic        we_m  [3];
  logic [3:0]  sel_m [3];
  logic [31:0] adr_m [3];
  logic [31:0] dat_m [3];
  logic [31:0] dat_s [3];
  logic        ack_s [3];
`ifdef WB_SLV_ERR_EN
  logic        err_s [3];
`endif

  int vectors     = 0;
  int miscompares = 0;

  wb_ram_slave_if bus0 ();
  wb_ram_slave_if bus1 ();
  wb_ram_slave_if bus2 ();

  assign bus0.cyc = cyc_m[0];  assign bus0.stb = stb_m[0];  assign bus0.we = we_m[0];
  assign bus0.sel = sel_m[0];  assign bus0.adr = adr_m[0];  assign bus0.dat_w = dat_m[0];
  assign dat_s[0] = bus0.dat_r; assign ack_s[0] = bus0.ack;
  assign bus1.cyc = cyc_m[1];  assign bus1.stb = stb_m[1];  assign bus1.we = we_m[1];
  assign bus1.sel = sel_m[1];  assign bus1.adr = adr_m[1];  assign bus1.dat_w = dat_m[1];
  assign dat_s[1] = bus1.dat_r; assign ack_s[1] = bus1.ack;
  assign bus2.cyc = cyc_m[2];  assign bus2.stb = stb_m[2];  assign bus2.we = we_m[2];
  assign bus2.sel = sel_m[2];  assign bus2.adr = adr_m[2];  assign bus2.dat_w = dat_m[2];
  assign dat_s[2] = bus2.dat_r; assign ack_s[2] = bus2.ack;
`ifdef WB_SLV_ERR_EN
  assign err_s[0] = bus0.err;  assign err_s[1] = bus1.err;  assign err_s[2] = bus2.err;
`endif

  wb_ram_slave #(.ADDR_W(10), .WAIT_STATES(1)) u_ws1 (.i_clk(clk), .i_arst_n(rst_n), .wb(bus0));
  wb_ram_slave #(.ADDR_W(10), .WAIT_STATES(3)) u_ws3 (.i_clk(clk), .i_arst_n(rst_n), .wb(bus1));
  wb_ram_slave #(.ADDR_W(10), .WAIT_STATES(0)) u_ws0 (.i_clk(clk), .i_arst_n(rst_n), .wb(bus2));

  task automatic idle_all();
    for (int k = 0; k < 3; k++) begin
      cyc_m[k] = 1'b0; stb_m[k] = 1'b0; we_m[k] = 1'b0;
      sel_m[k] = 4'h0; adr_m[k] = 32'h0; dat_m[k] = 32'h0;
    end
  endtask

  // Drives one request from a falling edge, drops it on the first response, watches 8 cycles.
  task automatic xfer(input int k, input logic we, input logic [3:0] s, input logic [31:0] a,
                      input logic [31:0] d, output int first, output int n_ack,
                      output int n_err, output logic [31:0] rd);
    first = -1; n_ack = 0; n_err = 0; rd = 32'h0;
    cyc_m[k] = 1'b1; stb_m[k] = 1'b1; we_m[k] = we;
    sel_m[k] = s; adr_m[k] = a; dat_m[k] = d;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (ack_s[k] === 1'b1) begin
        n_ack++;
        if (first < 0) begin first = c; rd = dat_s[k]; end
        cyc_m[k] = 1'b0; stb_m[k] = 1'b0;
      end
`ifdef WB_SLV_ERR_EN
      if (err_s[k] === 1'b1) begin
        n_err++;
        if (first < 0) begin first = c; rd = dat_s[k]; end
        cyc_m[k] = 1'b0; stb_m[k] = 1'b0;
      end
`endif
    end
    cyc_m[k] = 1'b0; stb_m[k] = 1'b0;
  endtask

  task automatic test_reset();
    int f, na, ne; logic [31:0] rd;
    for (int k = 0; k < 3; k++) begin
      vectors++;
      if (ack_s[k] !== 1'b0 || dat_s[k] !== 32'h0) begin
        miscompares++;
        $display("[TB] FAIL reset_outputs[%0d]: got ack=%b dat=%h, expected ack=0 dat=0", k, ack_s[k], dat_s[k]);
      end
    end
    rst_n = 1'b1;
    @(negedge clk);
    xfer(1, 1'b1, 4'hF, 32'h20, 32'hCAFEF00D, f, na, ne, rd);
    vectors++;
    if (f !== 4) begin miscompares++; $display("[TB] FAIL ws3_ack_cycle: got %0d, expected 4", f); end
    xfer(1, 1'b0, 4'hF, 32'h20, 32'h0, f, na, ne, rd);
    vectors++;
    if (rd !== 32'hCAFEF00D) begin miscompares++; $display("[TB] FAIL ws3_read: got %h, expected cafef00d", rd); end
    cyc_m[1] = 1'b1; stb_m[1] = 1'b1; we_m[1] = 1'b1;
    sel_m[1] = 4'hF; adr_m[1] = 32'h20; dat_m[1] = 32'h12345678;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    cyc_m[1] = 1'b0; stb_m[1] = 1'b0;
    #1;
    vectors++;
    if (ack_s[1] !== 1'b0 || dat_s[1] !== 32'h0) begin
      miscompares++;
      $display("[TB] FAIL reset_mid_wait: got ack=%b dat=%h, expected ack=0 dat=0", ack_s[1], dat_s[1]);
    end
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      vectors++;
      if (ack_s[1] !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_hold_ack: got %b, expected 0", ack_s[1]); end
    end
    rst_n = 1'b1;
    @(negedge clk);
    xfer(1, 1'b0, 4'hF, 32'h20, 32'h0, f, na, ne, rd);
    vectors++;
    if (rd !== 32'hCAFEF00D || f !== 4) begin
      miscompares++;
      $display("[TB] FAIL reset_no_write: got data=%h cycle=%0d, expected cafef00d cycle 4", rd, f);
    end
  endtask

  task automatic test_write_read();
    int f, na, ne; logic [31:0] rd;
    xfer(0, 1'b1, 4'hF, 32'h10, 32'hDEADBEEF, f, na, ne, rd);
    vectors++;
    if (f !== 2 || na !== 1) begin
      miscompares++;
      $display("[TB] FAIL ws1_write_ack: got cycle=%0d count=%0d, expected cycle 2 count 1", f, na);
    end
    xfer(0, 1'b0, 4'hF, 32'h10, 32'h0, f, na, ne, rd);
    vectors++;
    if (f !== 2 || rd !== 32'hDEADBEEF) begin
      miscompares++;
      $display("[TB] FAIL ws1_read: got cycle=%0d data=%h, expected cycle 2 deadbeef", f, rd);
    end
  endtask

  task automatic test_byte_lanes();
    int f, na, ne; logic [31:0] rd;
    xfer(0, 1'b1, 4'b0101, 32'h10, 32'h11223344, f, na, ne, rd);
    xfer(0, 1'b0, 4'hF, 32'h10, 32'h0, f, na, ne, rd);
    vectors++;
    if (rd !== 32'hDE22BE44) begin miscompares++; $display("[TB] FAIL byte_lanes: got %h, expected de22be44", rd); end
    xfer(0, 1'b1, 4'b0000, 32'h10, 32'hFFFFFFFF, f, na, ne, rd);
    vectors++;
    if (na !== 1) begin miscompares++; $display("[TB] FAIL sel0_ack: got %0d acks, expected 1", na); end
    xfer(0, 1'b0, 4'b0000, 32'h10, 32'h0, f, na, ne, rd);
    vectors++;
    if (rd !== 32'hDE22BE44) begin miscompares++; $display("[TB] FAIL sel0_data: got %h, expected de22be44", rd); end
  endtask

  task automatic test_abort();
    int f, na, ne, hits; logic [31:0] rd;
    xfer(1, 1'b1, 4'hF, 32'h30, 32'hA5A5A5A5, f, na, ne, rd);
    hits = 0;
    cyc_m[1] = 1'b1; stb_m[1] = 1'b1; we_m[1] = 1'b1;
    sel_m[1] = 4'hF; adr_m[1] = 32'h30; dat_m[1] = 32'h5A5A5A5A;
    @(negedge clk); if (ack_s[1] === 1'b1) hits++;
    @(negedge clk); if (ack_s[1] === 1'b1) hits++;
    stb_m[1] = 1'b0;
    @(negedge clk); if (ack_s[1] === 1'b1) hits++;
    vectors++;
    if (hits !== 0) begin miscompares++; $display("[TB] FAIL abort_ack: got %0d acks, expected 0", hits); end
    xfer(1, 1'b0, 4'hF, 32'h30, 32'h0, f, na, ne, rd);
    vectors++;
    if (na !== 1 || f !== 4 || rd !== 32'hA5A5A5A5) begin
      miscompares++;
      $display("[TB] FAIL abort_recover: got acks=%0d cycle=%0d data=%h, expected 1 4 a5a5a5a5", na, f, rd);
    end
  endtask

  task automatic test_back_to_back();
    int f, na, ne, idx, total; logic [31:0] rd;
    logic [31:0] exp_d [3];
    logic [31:0] got_d [3];
    int          ack_c [3];
    exp_d[0] = 32'h11111111; exp_d[1] = 32'h22222222; exp_d[2] = 32'h33333333;
    for (int i = 0; i < 3; i++) begin
      xfer(2, 1'b1, 4'hF, 32'h40 + i, exp_d[i], f, na, ne, rd);
      vectors++;
      if (f !== 1) begin miscompares++; $display("[TB] FAIL ws0_write_ack[%0d]: got %0d, expected 1", i, f); end
      got_d[i] = 32'h0; ack_c[i] = -1;
    end
    idx = 0; total = 0;
    cyc_m[2] = 1'b1; stb_m[2] = 1'b1; we_m[2] = 1'b0; sel_m[2] = 4'h0; adr_m[2] = 32'h40;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (ack_s[2] === 1'b1) begin
        total++;
        if (idx < 3) begin ack_c[idx] = c; got_d[idx] = dat_s[2]; idx++; end
        if (idx < 3) adr_m[2] = 32'h40 + idx;
        else begin cyc_m[2] = 1'b0; stb_m[2] = 1'b0; end
      end
    end
    cyc_m[2] = 1'b0; stb_m[2] = 1'b0;
    vectors++;
    if (total !== 3) begin miscompares++; $display("[TB] FAIL b2b_count: got %0d acks, expected 3", total); end
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (ack_c[i] !== 2*i + 1 || got_d[i] !== exp_d[i]) begin
        miscompares++;
        $display("[TB] FAIL b2b_read[%0d]: got cycle=%0d data=%h, expected cycle %0d data %h",
                 i, ack_c[i], got_d[i], 2*i + 1, exp_d[i]);
      end
    end
  endtask

  task automatic test_addr_range();
    int f, na, ne; logic [31:0] rd;
    xfer(0, 1'b1, 4'hF, 32'h0, 32'h0BADF00D, f, na, ne, rd);
    vectors++;
    if (f !== 2) begin miscompares++; $display("[TB] FAIL adr0_write: got cycle %0d, expected 2", f); end
    xfer(0, 1'b1, 4'hF, 32'h400, 32'h77777777, f, na, ne, rd);
`ifdef WB_SLV_ERR_EN
    vectors++;
    if (na !== 0 || ne !== 1 || f !== 2 || rd !== 32'h0) begin
      miscompares++;
      $display("[TB] FAIL err_resp: got ack=%0d err=%0d cycle=%0d dat=%h, expected 0 1 2 0", na, ne, f, rd);
    end
    xfer(0, 1'b0, 4'hF, 32'h0, 32'h0, f, na, ne, rd);
    vectors++;
    if (rd !== 32'h0BADF00D) begin miscompares++; $display("[TB] FAIL err_no_write: got %h, expected 0badf00d", rd); end
`else
    vectors++;
    if (na !== 1 || f !== 2) begin
      miscompares++;
      $display("[TB] FAIL alias_ack: got acks=%0d cycle=%0d, expected 1 2", na, f);
    end
    xfer(0, 1'b0, 4'hF, 32'h0, 32'h0, f, na, ne, rd);
    vectors++;
    if (rd !== 32'h77777777) begin miscompares++; $display("[TB] FAIL alias_write: got %h, expected 77777777", rd); end
`endif
  endtask

  initial begin
    rst_n = 1'b0;
    idle_all();
    repeat (2) @(negedge clk);
    test_reset();
    test_write_read();
    test_byte_lanes();
    test_abort();
    test_back_to_back();
    test_addr_range();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
